// File: rtl/axi_wr_4k_split.sv
// AXI write-burst splitter: cuts INCR bursts at BOUNDARY-byte address boundaries,
// regenerates wlast per sub-burst and merges the B responses into one upstream response.
module axi_wr_4k_split #(
  parameter int ASIZE     = 29,
  parameter int LSIZE     = 9,
  parameter int AXI_DSIZE = 256,
  parameter int IDSIZE    = 4,
  parameter int BOUNDARY  = 4096
) (
  input  logic                   axi_aclk,
  input  logic                   axi_rst,
  input  logic [IDSIZE-1:0]      s_awid,
  input  logic [ASIZE-1:0]       s_awaddr,
  input  logic [LSIZE-1:0]       s_awlen,
  input  logic                   s_awvalid,
  output logic                   s_awready,
  input  logic [AXI_DSIZE-1:0]   s_wdata,
  input  logic [AXI_DSIZE/8-1:0] s_wstrb,
  input  logic                   s_wlast,
  input  logic                   s_wvalid,
  output logic                   s_wready,
  output logic [IDSIZE-1:0]      s_bid,
  output logic [1:0]             s_bresp,
  output logic                   s_bvalid,
  input  logic                   s_bready,
  output logic [IDSIZE-1:0]      m_awid,
  output logic [ASIZE-1:0]       m_awaddr,
  output logic [LSIZE-1:0]       m_awlen,
  output logic [2:0]             m_awsize,
  output logic [1:0]             m_awburst,
  output logic                   m_awvalid,
  input  logic                   m_awready,
  output logic [AXI_DSIZE-1:0]   m_wdata,
  output logic [AXI_DSIZE/8-1:0] m_wstrb,
  output logic                   m_wlast,
  output logic                   m_wvalid,
  input  logic                   m_wready,
  input  logic [IDSIZE-1:0]      m_bid,
  input  logic [1:0]             m_bresp,
  input  logic                   m_bvalid,
  output logic                   m_bready,
  output logic                   wlast_err
);

  localparam int BEAT_BYTES = AXI_DSIZE / 8;
  localparam int BB_SHIFT   = $clog2(BEAT_BYTES);
  localparam int OFF_W      = $clog2(BOUNDARY);
  localparam logic [LSIZE:0] REM_ONE  = {{LSIZE{1'b0}}, 1'b1};
  localparam logic [LSIZE:0] REM_ZERO = {(LSIZE+1){1'b0}};

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    M_AW = 3'd1,
    M_W  = 3'd2,
    M_B  = 3'd3,
    S_B  = 3'd4
  } state_t;

  // awlen of the next piece: min(remaining, beats left before the boundary) - 1
  function automatic logic [LSIZE-1:0] calc_len(input logic [OFF_W-1:0] off,
                                                input logic [LSIZE:0]   rem);
    logic [31:0] room_v;
    logic [31:0] piece_v;
    room_v = 32'(BOUNDARY / BEAT_BYTES) - 32'(off >> BB_SHIFT);
    if (32'(rem) < room_v) begin
      piece_v = 32'(rem);
    end else begin
      piece_v = room_v;
    end
    return LSIZE'(piece_v - 32'd1);
  endfunction

  state_t              state_r;
  state_t              state_nxt_s;
  logic [IDSIZE-1:0]   id_r;
  logic [ASIZE-1:0]    addr_r;
  logic [LSIZE:0]      rem_r;
  logic [LSIZE-1:0]    len_r;
  logic [LSIZE-1:0]    beat_r;
  logic [1:0]          resp_r;

  logic                w_hs_s;
  logic                last_beat_s;
  logic [LSIZE:0]      first_rem_s;
  logic [LSIZE-1:0]    first_len_s;
  logic [ASIZE-1:0]    addr_nxt_s;
  logic [LSIZE:0]      rem_nxt_s;
  logic [LSIZE-1:0]    next_len_s;
  logic                unused_s;

  assign unused_s    = ^m_bid;
  assign w_hs_s      = (state_r == M_W) & s_wvalid & m_wready;
  assign last_beat_s = (beat_r == len_r);
  assign first_rem_s = {1'b0, s_awlen} + REM_ONE;
  assign first_len_s = calc_len(s_awaddr[OFF_W-1:0], first_rem_s);
  assign addr_nxt_s  = addr_r + ((ASIZE'(len_r) + ASIZE'(32'd1)) << BB_SHIFT);
  assign rem_nxt_s   = rem_r - ({1'b0, len_r} + REM_ONE);
  assign next_len_s  = calc_len(addr_nxt_s[OFF_W-1:0], rem_nxt_s);

  // Control outputs decode straight from the state register; the W path is a pass-through.
  assign s_awready = (state_r == IDLE);
  assign m_awvalid = (state_r == M_AW);
  assign m_awid    = id_r;
  assign m_awaddr  = addr_r;
  assign m_awlen   = len_r;
  assign m_awsize  = 3'(BB_SHIFT);
  assign m_awburst = 2'b01;
  assign s_wready  = (state_r == M_W) & m_wready;
  assign m_wvalid  = (state_r == M_W) & s_wvalid;
  assign m_wdata   = s_wdata;
  assign m_wstrb   = s_wstrb;
  assign m_wlast   = (state_r == M_W) & last_beat_s;
  assign m_bready  = (state_r == M_B);
  assign s_bvalid  = (state_r == S_B);
  assign s_bid     = id_r;
  assign s_bresp   = resp_r;
  assign wlast_err = w_hs_s & (s_wlast != (last_beat_s & (rem_nxt_s == REM_ZERO)));

  // State register
  always_ff @(posedge axi_aclk) begin
    if (axi_rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (s_awvalid) begin
          state_nxt_s = M_AW;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      M_AW: begin
        if (m_awready) begin
          state_nxt_s = M_W;
        end else begin
          state_nxt_s = M_AW;
        end
      end
      M_W: begin
        if (w_hs_s && last_beat_s) begin
          state_nxt_s = M_B;
        end else begin
          state_nxt_s = M_W;
        end
      end
      M_B: begin
        if (!m_bvalid) begin
          state_nxt_s = M_B;
        end else if (rem_r != REM_ZERO) begin
          state_nxt_s = M_AW;
        end else begin
          state_nxt_s = S_B;
        end
      end
      S_B: begin
        if (s_bready) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = S_B;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Burst bookkeeping; the next piece's awlen is prepared at the last W beat so m_aw* is registered
  always_ff @(posedge axi_aclk) begin
    if (axi_rst) begin
      id_r   <= {IDSIZE{1'b0}};
      addr_r <= {ASIZE{1'b0}};
      rem_r  <= REM_ZERO;
      len_r  <= {LSIZE{1'b0}};
      beat_r <= {LSIZE{1'b0}};
      resp_r <= 2'b00;
    end else begin
      case (state_r)
        IDLE: begin
          if (s_awvalid) begin
            id_r   <= s_awid;
            addr_r <= s_awaddr;
            rem_r  <= first_rem_s;
            len_r  <= first_len_s;
            resp_r <= 2'b00;
          end
        end
        M_AW: begin
          if (m_awready) begin
            beat_r <= {LSIZE{1'b0}};
          end
        end
        M_W: begin
          if (w_hs_s) begin
            if (last_beat_s) begin
              addr_r <= addr_nxt_s;
              rem_r  <= rem_nxt_s;
              len_r  <= next_len_s;
            end else begin
              beat_r <= beat_r + {{(LSIZE-1){1'b0}}, 1'b1};
            end
          end
        end
        M_B: begin
          // Numeric max gives DECERR > SLVERR > OKAY
          if (m_bvalid && (m_bresp > resp_r)) begin
            resp_r <= m_bresp;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axi_wr_4k_split.sv
// Self-checking bench for axi_wr_4k_split: directed bursts with a scoreboard of
// expected sub-bursts, W beats and merged B responses.
module tb_axi_wr_4k_split;

  logic         clk = 1'b0;
  logic         axi_rst;
  logic [3:0]   s_awid;
  logic [28:0]  s_awaddr;
  logic [8:0]   s_awlen;
  logic         s_awvalid, s_awready;
  logic [255:0] s_wdata;
  logic [31:0]  s_wstrb;
  logic         s_wlast, s_wvalid, s_wready;
  logic [3:0]   s_bid;
  logic [1:0]   s_bresp;
  logic         s_bvalid, s_bready;
  logic [3:0]   m_awid;
  logic [28:0]  m_awaddr;
  logic [8:0]   m_awlen;
  logic [2:0]   m_awsize;
  logic [1:0]   m_awburst;
  logic         m_awvalid, m_awready;
  logic [255:0] m_wdata;
  logic [31:0]  m_wstrb;
  logic         m_wlast, m_wvalid, m_wready;
  logic [3:0]   m_bid;
  logic [1:0]   m_bresp;
  logic         m_bvalid, m_bready;
  logic         wlast_err;

  always #5 clk = ~clk;

  axi_wr_4k_split dut (
    .axi_aclk(clk), .axi_rst(axi_rst),
    .s_awid(s_awid), .s_awaddr(s_awaddr), .s_awlen(s_awlen),
    .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wlast(s_wlast),
    .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bid(s_bid), .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .m_awid(m_awid), .m_awaddr(m_awaddr), .m_awlen(m_awlen),
    .m_awsize(m_awsize), .m_awburst(m_awburst),
    .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast),
    .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_bid(m_bid), .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
    .wlast_err(wlast_err)
  );

  typedef struct { logic [28:0] addr; logic [8:0] len; logic [3:0] id; } aw_exp_t;
  typedef struct { logic [255:0] data; logic [31:0] strb; logic last; logic err; } w_exp_t;

  aw_exp_t    exp_aw_q[$];
  w_exp_t     exp_w_q[$];
  logic [5:0] exp_b_q[$];
  logic [1:0] bresp_q[$];

  int n_checks = 0;
  int n_fail   = 0;
  int aw_delay = 0;
  int aw_wait  = 0;
  bit wrand    = 1'b0;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // Downstream slave model, driven on the falling edge
  always @(negedge clk) begin
    m_awready = m_awvalid && (aw_wait >= aw_delay);
    aw_wait   = m_awvalid ? aw_wait + 1 : 0;
    m_wready  = wrand ? 1'($urandom_range(0, 1)) : 1'b1;
    m_bvalid  = m_bready;
    m_bresp   = (bresp_q.size() > 0) ? bresp_q[0] : 2'b00;
    m_bid     = 4'hF;
  end

  // Monitor: samples 1 time unit before each rising edge and pops the scoreboard
  bit          in_piece = 1'b0;
  bit          aw_hold  = 1'b0;
  logic [28:0] hold_addr;
  logic [8:0]  hold_len;
  always begin
    aw_exp_t ea;
    w_exp_t  ew;
    logic [5:0] eb;
    @(negedge clk);
    #4;
    if (axi_rst) begin
      exp_aw_q.delete(); exp_w_q.delete(); exp_b_q.delete(); bresp_q.delete();
      in_piece = 1'b0;
      aw_hold  = 1'b0;
    end else begin
      if (aw_hold && m_awvalid) begin
        chk("aw_addr_stable", 256'(m_awaddr), 256'(hold_addr));
        chk("aw_len_stable", 256'(m_awlen), 256'(hold_len));
      end
      if (!in_piece) chk("s_wready_before_aw", 256'(s_wready), 256'(1'b0));
      if (m_awvalid && m_awready) begin
        aw_hold = 1'b0;
        if (exp_aw_q.size() == 0) begin
          chk("aw_unexpected", 256'(1'b1), 256'(1'b0));
        end else begin
          ea = exp_aw_q.pop_front();
          chk("m_awaddr", 256'(m_awaddr), 256'(ea.addr));
          chk("m_awlen", 256'(m_awlen), 256'(ea.len));
          chk("m_awid", 256'(m_awid), 256'(ea.id));
        end
        in_piece = 1'b1;
      end else if (m_awvalid) begin
        aw_hold   = 1'b1;
        hold_addr = m_awaddr;
        hold_len  = m_awlen;
      end else begin
        aw_hold = 1'b0;
      end
      if (m_wvalid && m_wready) begin
        if (exp_w_q.size() == 0) begin
          chk("w_unexpected", 256'(1'b1), 256'(1'b0));
        end else begin
          ew = exp_w_q.pop_front();
          chk("m_wdata", m_wdata, ew.data);
          chk("m_wstrb", 256'(m_wstrb), 256'(ew.strb));
          chk("m_wlast", 256'(m_wlast), 256'(ew.last));
          chk("wlast_err", 256'(wlast_err), 256'(ew.err));
          if (ew.last) in_piece = 1'b0;
        end
      end else begin
        chk("wlast_err_idle", 256'(wlast_err), 256'(1'b0));
      end
      if (m_bvalid && m_bready) begin
        if (bresp_q.size() == 0) chk("m_b_unexpected", 256'(1'b1), 256'(1'b0));
        else void'(bresp_q.pop_front());
      end
      if (s_bvalid && s_bready) begin
        if (exp_b_q.size() == 0) begin
          chk("s_b_unexpected", 256'(1'b1), 256'(1'b0));
        end else begin
          eb = exp_b_q.pop_front();
          chk("s_bid", 256'(s_bid), 256'(eb[5:2]));
          chk("s_bresp", 256'(s_bresp), 256'(eb[1:0]));
        end
      end
    end
  end

  // One upstream burst: build the expected pieces, then drive AW, W and wait for B.
  // resps[2i+:2] answers piece i; bad_beat is a 0-based beat with a spurious s_wlast;
  // abort_after > 0 stops after that many beats and leaves the DUT mid-burst.
  task automatic run_burst(input logic [3:0] id, input logic [28:0] addr, input int len,
                           input logic [7:0] resps, input int bad_beat, input int abort_after);
    logic [28:0]  a = addr;
    int           rem = len + 1;
    int           room, p, beat = 0, npiece = 0, nsend;
    logic [1:0]   exp_resp = 2'b00, r;
    logic [255:0] d;
    logic [31:0]  s;
    logic         dl;
    logic [255:0] drv_d[$];
    logic [31:0]  drv_s[$];
    logic         drv_l[$];
    bit           done;
    while (rem > 0) begin
      room = (4096 - int'(a[11:0])) / 32;
      p = (rem < room) ? rem : room;
      exp_aw_q.push_back('{a, 9'(p - 1), id});
      r = resps[2 * ((npiece < 3) ? npiece : 3) +: 2];
      bresp_q.push_back(r);
      if (r > exp_resp) exp_resp = r;
      for (int k = 0; k < p; k++) begin
        for (int j = 0; j < 8; j++) d[32 * j +: 32] = $urandom;
        s  = $urandom;
        dl = (beat == len) || (beat == bad_beat);
        drv_d.push_back(d); drv_s.push_back(s); drv_l.push_back(dl);
        exp_w_q.push_back('{d, s, (k == p - 1), (dl != (beat == len))});
        beat++;
      end
      a = a + 29'(p * 32);
      rem -= p;
      npiece++;
    end
    if (abort_after == 0) exp_b_q.push_back({id, exp_resp});
    @(negedge clk);
    s_awid = id; s_awaddr = addr; s_awlen = 9'(len); s_awvalid = 1'b1;
    done = 1'b0;
    for (int t = 0; t < 200 && !done; t++) begin
      #4; done = s_awready; @(negedge clk);
    end
    if (!done) chk("s_aw_timeout", 256'(1'b0), 256'(1'b1));
    s_awvalid = 1'b0;
    nsend = (abort_after > 0) ? abort_after : len + 1;
    for (int i = 0; i < nsend; i++) begin
      s_wvalid = 1'b1; s_wdata = drv_d[i]; s_wstrb = drv_s[i]; s_wlast = drv_l[i];
      done = 1'b0;
      for (int t = 0; t < 500 && !done; t++) begin
        #4; done = s_wready; @(negedge clk);
      end
      if (!done) begin
        chk("s_w_timeout", 256'(1'b0), 256'(1'b1));
        break;
      end
    end
    s_wvalid = 1'b0; s_wlast = 1'b0;
    if (abort_after == 0) begin
      for (int t = 0; t < 3000 && exp_b_q.size() != 0; t++) @(negedge clk);
      if (exp_b_q.size() != 0) chk("s_b_timeout", 256'(1'b0), 256'(1'b1));
    end
  endtask

  initial begin
    axi_rst = 1'b1;
    s_awid = 4'h0; s_awaddr = 29'h0; s_awlen = 9'h0; s_awvalid = 1'b0;
    s_wdata = 256'h0; s_wstrb = 32'h0; s_wlast = 1'b0; s_wvalid = 1'b0;
    s_bready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_s_awready", 256'(s_awready), 256'(1'b1));
    chk("rst_m_awvalid", 256'(m_awvalid), 256'(1'b0));
    chk("rst_s_wready", 256'(s_wready), 256'(1'b0));
    chk("rst_m_wvalid", 256'(m_wvalid), 256'(1'b0));
    chk("rst_m_wlast", 256'(m_wlast), 256'(1'b0));
    chk("rst_m_bready", 256'(m_bready), 256'(1'b0));
    chk("rst_s_bvalid", 256'(s_bvalid), 256'(1'b0));
    chk("rst_s_bresp", 256'(s_bresp), 256'(2'b00));
    chk("rst_wlast_err", 256'(wlast_err), 256'(1'b0));
    chk("m_awsize", 256'(m_awsize), 256'(3'd5));
    chk("m_awburst", 256'(m_awburst), 256'(2'b01));
    axi_rst = 1'b0;
    @(negedge clk);

    run_burst(4'h3, 29'h0000, 63, 8'h00, -1, 0);
    run_burst(4'h5, 29'h0F00, 15, 8'h00, -1, 0);
    run_burst(4'hA, 29'h0000, 511, 8'h00, -1, 0);
    run_burst(4'h1, 29'h0F00, 15, 8'b0000_1000, -1, 0);
    run_burst(4'h2, 29'h0F00, 15, 8'b0000_0011, -1, 0);
    run_burst(4'h7, 29'h1FFF_FFE0, 1, 8'h00, -1, 0);

    aw_delay = 5; wrand = 1'b1;
    run_burst(4'h9, 29'h1FC0, 9, 8'h00, -1, 0);
    run_burst(4'hC, 29'h2F80, 40, 8'b0000_0100, -1, 0);
    aw_delay = 0; wrand = 1'b0;

    run_burst(4'h4, 29'h0F00, 15, 8'h00, 7, 0);
    repeat (2) @(negedge clk);
    chk("sb_drain", 256'(exp_aw_q.size() + exp_w_q.size() + bresp_q.size() + exp_b_q.size()), 256'(0));

    run_burst(4'h6, 29'h0F00, 15, 8'h00, -1, 5);
    axi_rst = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_rst_s_awready", 256'(s_awready), 256'(1'b1));
    chk("mid_rst_m_awvalid", 256'(m_awvalid), 256'(1'b0));
    chk("mid_rst_s_wready", 256'(s_wready), 256'(1'b0));
    chk("mid_rst_m_wvalid", 256'(m_wvalid), 256'(1'b0));
    chk("mid_rst_m_wlast", 256'(m_wlast), 256'(1'b0));
    chk("mid_rst_m_bready", 256'(m_bready), 256'(1'b0));
    chk("mid_rst_s_bvalid", 256'(s_bvalid), 256'(1'b0));
    @(negedge clk);
    axi_rst = 1'b0;
    @(negedge clk);
    run_burst(4'hB, 29'h0040, 3, 8'h00, -1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/axi_wr_4k_split.md
# axi_wr_4k_split

AXI write-burst splitter between the VDMA write engine's AXI master port (AW/W/B) and the memory interconnect. Each upstream INCR burst that would cross a BOUNDARY-byte address boundary is cut into legal sub-bursts; W-channel `wlast` is regenerated per sub-burst and the B responses are merged into a single upstream response. Bursts are processed one at a time: one sub-burst AW, then its W beats, then its B. Throughput is traded for a small, deterministic design.

## Interface
Parameters:
- ASIZE, 29: address width.
- LSIZE, 9: awlen width. Burst length is awlen+1, up to 512 beats.
- AXI_DSIZE, 256: data width. BEAT_BYTES = AXI_DSIZE/8.
- IDSIZE, 4: ID width.
- BOUNDARY, 4096: split boundary in bytes; power of two, ≥ BEAT_BYTES.

Ports:
- Clock and reset: one clock; reset is synchronous and active-high.
  - axi_aclk  in  1  clock.
  - axi_rst  in  1  synchronous, active-high reset.
- Upstream AW (slave side):
  - s_awid/s_awaddr/s_awlen  in  IDSIZE/ASIZE/LSIZE  upstream request. Address is beat-aligned; awsize = log2(BEAT_BYTES); awburst is INCR.
  - s_awvalid  in  1; s_awready  out  1.
- Upstream W (slave side):
  - s_wdata  in  AXI_DSIZE.
  - s_wstrb  in  AXI_DSIZE/8.
  - s_wlast  in  1.
  - s_wvalid  in  1; s_wready  out  1.
- Upstream B (slave side):
  - s_bid  out  IDSIZE.
  - s_bresp  out  2.
  - s_bvalid  out  1; s_bready  in  1.
- Downstream AW (master side):
  - m_awid/m_awaddr/m_awlen  out  IDSIZE/ASIZE/LSIZE.
  - m_awsize  out  3, constant log2(BEAT_BYTES).
  - m_awburst  out  2, constant 2'b01.
  - m_awvalid  out  1; m_awready  in  1.
- Downstream W (master side):
  - m_wdata  out  AXI_DSIZE.
  - m_wstrb  out  AXI_DSIZE/8.
  - m_wlast  out  1.
  - m_wvalid  out  1; m_wready  in  1.
- Downstream B (master side):
  - m_bid  in  IDSIZE.
  - m_bresp  in  2.
  - m_bvalid  in  1; m_bready  out  1.
- Status:
  - wlast_err  out  1  one-cycle pulse when s_wlast disagrees with the expected last beat of the upstream burst.

## Operation
- State machine: IDLE → M_AW → M_W → M_B → (M_AW | S_B) → IDLE.
- **IDLE**
  - s_awready=1.
  - On the s_aw handshake, capture id, addr and remaining = s_awlen+1 (LSIZE+1 bits). Clear resp_acc to 2'b00. Go to M_AW.
- **M_AW**
  - off = addr mod BOUNDARY.
  - room = (BOUNDARY − off)/BEAT_BYTES.
  - piece = min(remaining, room).
  - Outputs: m_awaddr=addr, m_awlen=piece−1, m_awid=id, m_awvalid=1.
  - Outputs are registered and held stable until m_awready.
  - On the handshake, latch piece and beat_cnt=0, then go to M_W.
- **M_W**
  - Pass-through: m_wvalid=s_wvalid, s_wready=m_wready, m_wdata=s_wdata, m_wstrb=s_wstrb.
  - m_wlast = (beat_cnt == piece−1).
  - On each W handshake, beat_cnt++.
  - On the last beat:
    - addr += piece·BEAT_BYTES, modulo 2^ASIZE.
    - remaining −= piece.
    - Go to M_B.
- **M_B**
  - m_bready=1.
  - On m_bvalid: resp_acc = max(resp_acc, m_bresp), compared numerically so DECERR > SLVERR > OKAY.
  - m_bid is ignored.
  - Next state: M_AW if remaining≠0, else S_B.
- **S_B**
  - s_bvalid=1, s_bid=id, s_bresp=resp_acc.
  - Hold until s_bready, then go to IDLE.
- **wlast_err**
  - Pulses on any W handshake where s_wlast ≠ (last beat of the last piece).
  - Data is forwarded regardless.
- s_wready=0 and m_wvalid=0 outside M_W. W beats arriving early are stalled, not dropped.

## Timing
- Reset values: every valid/ready output is 0, except s_awready=1. State is IDLE; m_awlast/m_wlast=0; s_bresp=0; wlast_err=0.
- Reset is applied on the clock edge only.
- Reset mid-burst aborts everything. There is no downstream cleanup; the owner resets the interconnect together with this block.
- s_aw handshake at cycle N → m_awvalid=1 at N+1.
- m_aw handshake at N → s_wready may be asserted at N+1.
- Last W handshake at N → m_bready=1 at N+1.
- m_b handshake at N → next m_awvalid at N+1, or s_bvalid at N+1.
- The W path adds zero latency; it is combinational in M_W.
- An unsplit burst costs 4 bookkeeping cycles plus the data beats.
- A piece exactly equal to room ends on the boundary; the next piece starts at off=0.
- The largest burst, 512 beats with BOUNDARY=4096 and 32-byte beats, splits into 4 pieces of 128 beats.

## Test plan
- addr 0x0000, awlen 63 → one piece:
  - m_awaddr 0x0000, m_awlen 63.
  - m_wlast on beat 64.
  - s_bresp 2'b00, s_bid = s_awid.
- addr 0x0F00, awlen 15 → two pieces, (0x0F00, len 7) and (0x1000, len 7):
  - m_wlast on beats 8 and 16.
  - Exactly one s_bvalid.
- addr 0x0000, awlen 511 → four pieces at 0x0000, 0x1000, 0x2000, 0x3000, each with m_awlen 127.
- Response merge:
  - Two-piece burst answered OKAY then SLVERR → s_bresp 2'b10.
  - Answered DECERR then OKAY → 2'b11.
- Backpressure:
  - m_awready delayed 5 cycles and m_wready random 50% → m_awaddr/m_awlen stable while m_awvalid is high.
  - All data beats arrive in order with no loss.
  - s_wready is 0 before the first m_aw handshake.
- Error and reset:
  - s_wlast asserted on beat 8 of a 16-beat burst → wlast_err pulses on that beat, and m_wlast stays per-piece.
  - axi_rst asserted in M_W → next edge: s_awready=1, all other valids and readys 0.
